// File: rtl/agu_pipelined.sv
// rtl/agu_pipelined.sv - registered multi-channel effective-address stage with skid buffer
// Each channel: base + index<<scale + disp, or RIP + disp + len; canonical fault per channel.
module agu_pipelined #(
    parameter int AW      = 64,
    parameter int NCH     = 3,
    parameter int VA_BITS = 48,
    parameter int TAG_W   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_rip,
    input  logic [7:0]          in_instr_len,
    input  logic [AW-1:0]       in_disp,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic [NCH-1:0]      in_mem_en,
    input  logic [NCH-1:0]      in_use_rip,
    input  logic [NCH-1:0]      in_index_en,
    input  logic [NCH*AW-1:0]   in_base,
    input  logic [NCH*AW-1:0]   in_index,
    input  logic [2*NCH-1:0]    in_scale,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [AW-1:0]       out_rip,
    output logic [TAG_W-1:0]    out_tag,
    output logic [NCH-1:0]      out_addr_valid,
    output logic [NCH*AW-1:0]   out_addr,
    output logic [NCH-1:0]      out_fault
);

    localparam int HB = AW - VA_BITS + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]     len_ext;
    logic [NCH*AW-1:0] ea_c;
    logic [NCH-1:0]    flt_c;

    assign len_ext = {{(AW-8){1'b0}}, in_instr_len};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [AW-1:0] base_w;
        logic [AW-1:0] index_w;
        logic [AW-1:0] scaled_w;
        logic [AW-1:0] ea_w;
        logic [1:0]    scale_w;
        logic [HB-1:0] top_w;

        assign base_w   = in_base[c*AW +: AW];
        assign index_w  = in_index[c*AW +: AW];
        assign scale_w  = in_scale[2*c +: 2];
        assign scaled_w = in_index_en[c] ? (index_w << scale_w) : '0;
        assign ea_w     = !in_mem_en[c]  ? '0
                        : in_use_rip[c]  ? (in_rip + in_disp + len_ext)
                        :                  (base_w + scaled_w + in_disp);
        // Canonical means the bits above the implemented VA all copy bit VA_BITS-1.
        assign top_w    = ea_w[AW-1:VA_BITS-1];
        assign ea_c[c*AW +: AW] = ea_w;
        assign flt_c[c] = in_mem_en[c] & ~((&top_w) | ~(|top_w));
    end

    logic [AW-1:0]     main_rip_q,   skid_rip_q;
    logic [TAG_W-1:0]  main_tag_q,   skid_tag_q;
    logic [NCH-1:0]    main_av_q,    skid_av_q;
    logic [NCH*AW-1:0] main_addr_q,  skid_addr_q;
    logic [NCH-1:0]    main_flt_q,   skid_flt_q;

    logic acc, xfer;
    logic ld_main_in, ld_main_skid, ld_skid;

    assign in_ready  = (state_q != FULL2);
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d    = FULL1;
                        ld_main_in = 1'b1;
                    end
                end
                FULL1: begin
                    if (acc && !xfer) begin
                        state_d = FULL2;
                        ld_skid = 1'b1;
                    end else if (acc && xfer) begin
                        ld_main_in = 1'b1;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL2: begin
                    if (xfer) begin
                        state_d      = FULL1;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_rip_q  <= '0;
            main_tag_q  <= '0;
            main_av_q   <= '0;
            main_addr_q <= '0;
            main_flt_q  <= '0;
        end else if (ld_main_in) begin
            main_rip_q  <= in_rip;
            main_tag_q  <= in_tag;
            main_av_q   <= in_mem_en;
            main_addr_q <= ea_c;
            main_flt_q  <= flt_c;
        end else if (ld_main_skid) begin
            main_rip_q  <= skid_rip_q;
            main_tag_q  <= skid_tag_q;
            main_av_q   <= skid_av_q;
            main_addr_q <= skid_addr_q;
            main_flt_q  <= skid_flt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_rip_q  <= '0;
            skid_tag_q  <= '0;
            skid_av_q   <= '0;
            skid_addr_q <= '0;
            skid_flt_q  <= '0;
        end else if (ld_skid) begin
            skid_rip_q  <= in_rip;
            skid_tag_q  <= in_tag;
            skid_av_q   <= in_mem_en;
            skid_addr_q <= ea_c;
            skid_flt_q  <= flt_c;
        end
    end

    assign out_rip        = main_rip_q;
    assign out_tag        = main_tag_q;
    assign out_addr_valid = main_av_q;
    assign out_addr       = main_addr_q;
    assign out_fault      = main_flt_q;

endmodule

// File: tb/tb_agu_pipelined.sv
// tb/tb_agu_pipelined.sv - directed and random checks of agu_pipelined against a queue model
module tb_agu_pipelined;

    localparam int AW      = 64;
    localparam int NCH     = 3;
    localparam int VA_BITS = 48;
    localparam int TAG_W   = 32;

    logic                clk;
    logic                reset_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [AW-1:0]       in_rip;
    logic [7:0]          in_instr_len;
    logic [AW-1:0]       in_disp;
    logic [TAG_W-1:0]    in_tag;
    logic [NCH-1:0]      in_mem_en;
    logic [NCH-1:0]      in_use_rip;
    logic [NCH-1:0]      in_index_en;
    logic [NCH*AW-1:0]   in_base;
    logic [NCH*AW-1:0]   in_index;
    logic [2*NCH-1:0]    in_scale;
    logic                out_valid;
    logic                out_ready;
    logic [AW-1:0]       out_rip;
    logic [TAG_W-1:0]    out_tag;
    logic [NCH-1:0]      out_addr_valid;
    logic [NCH*AW-1:0]   out_addr;
    logic [NCH-1:0]      out_fault;

    agu_pipelined #(.AW(AW), .NCH(NCH), .VA_BITS(VA_BITS), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rip         (in_rip),
        .in_instr_len   (in_instr_len),
        .in_disp        (in_disp),
        .in_tag         (in_tag),
        .in_mem_en      (in_mem_en),
        .in_use_rip     (in_use_rip),
        .in_index_en    (in_index_en),
        .in_base        (in_base),
        .in_index       (in_index),
        .in_scale       (in_scale),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rip        (out_rip),
        .out_tag        (out_tag),
        .out_addr_valid (out_addr_valid),
        .out_addr       (out_addr),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]     rip;
        logic [TAG_W-1:0]  tag;
        logic [NCH-1:0]    av;
        logic [NCH*AW-1:0] addr;
        logic [NCH-1:0]    flt;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] ref_ea(input int c);
        logic [AW-1:0] idx_term;
        if (!in_mem_en[c]) return '0;
        if (in_use_rip[c]) return in_rip + in_disp + 64'(in_instr_len);
        idx_term = in_index_en[c] ? in_index[c*AW +: AW] * (64'd1 << in_scale[2*c +: 2]) : 64'd0;
        return in_base[c*AW +: AW] + idx_term + in_disp;
    endfunction

    function automatic logic ref_fault(input logic [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a << (AW - VA_BITS);
        s = s >>> (AW - VA_BITS);
        return s != a;
    endfunction

    function automatic exp_t ref_entry();
        exp_t e;
        logic [AW-1:0] a;
        e.rip  = in_rip;
        e.tag  = in_tag;
        e.av   = in_mem_en;
        e.addr = '0;
        e.flt  = '0;
        for (int c = 0; c < NCH; c++) begin
            a = ref_ea(c);
            e.addr[c*AW +: AW] = a;
            e.flt[c] = in_mem_en[c] && ref_fault(a);
        end
        return e;
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            check("out_rip", out_rip, q[0].rip);
            check("out_tag", out_tag, q[0].tag);
            check("out_addr_valid", out_addr_valid, q[0].av);
            check("out_addr", out_addr, q[0].addr);
            check("out_fault", out_fault, q[0].flt);
        end
    endtask

    // Advance one clock, updating the model with what the DUT saw at the edge.
    task automatic step();
        bit acc, xfer;
        @(posedge clk);
        acc  = in_valid && (q.size() < 2);
        xfer = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc) q.push_back(ref_entry());
        end
        #1;
        check_outputs();
    endtask

    task automatic clear_inputs();
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_rip       = '0;
        in_instr_len = '0;
        in_disp      = '0;
        in_tag       = '0;
        in_mem_en    = '0;
        in_use_rip   = '0;
        in_index_en  = '0;
        in_base      = '0;
        in_index     = '0;
        in_scale     = '0;
    endtask

    task automatic randomize_inputs();
        in_valid     = ($urandom % 10) < 7;
        in_rip       = {$urandom, $urandom};
        in_instr_len = 8'($urandom);
        in_disp      = ($urandom % 2) ? {{32{1'b1}}, $urandom} : {32'h0, $urandom};
        in_tag       = $urandom;
        in_mem_en    = 3'($urandom);
        in_use_rip   = 3'($urandom);
        in_index_en  = 3'($urandom);
        in_scale     = 6'($urandom);
        for (int c = 0; c < NCH; c++) begin
            in_base[c*AW +: AW]  = ($urandom % 2) ? {16'h0, 16'($urandom), $urandom} : {$urandom, $urandom};
            in_index[c*AW +: AW] = ($urandom % 2) ? {32'h0, $urandom} : {$urandom, $urandom};
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_addr", out_addr, '0);
        check("rst_out_rip", out_rip, '0);
        check("rst_out_tag", out_tag, '0);
        check("rst_out_av", out_addr_valid, '0);
        check("rst_out_fault", out_fault, '0);
        reset_n = 1'b1;

        // RIP-relative
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        in_rip       = 64'h40_0000;
        in_disp      = 64'h10;
        in_instr_len = 8'd7;
        in_mem_en    = 3'b001;
        in_use_rip   = 3'b001;
        step();
        check("rip_addr", out_addr[63:0], 64'h40_0017);
        check("rip_fault", out_fault[0], 1'b0);
        check("rip_valid", out_valid, 1'b1);

        // SIB on channel 1
        clear_inputs();
        in_valid         = 1'b1;
        in_mem_en        = 3'b010;
        in_index_en      = 3'b010;
        in_base[127:64]  = 64'h1000;
        in_index[127:64] = 64'h20;
        in_scale[3:2]    = 2'd3;
        in_disp          = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        check("sib_addr1", out_addr[127:64], 64'h10F8);
        check("sib_addr0", out_addr[63:0], 64'h0);
        check("sib_addr2", out_addr[191:128], 64'h0);

        // Wrap and canonical fault
        clear_inputs();
        in_valid       = 1'b1;
        in_mem_en      = 3'b001;
        in_base[63:0]  = 64'hFFFF_FFFF_FFFF_FFF0;
        in_disp        = 64'h20;
        step();
        check("wrap_addr", out_addr[63:0], 64'h10);
        check("wrap_fault", out_fault[0], 1'b0);
        in_base[63:0]  = 64'h0000_8000_0000_0000;
        in_disp        = 64'h0;
        step();
        check("noncanon_fault", out_fault[0], 1'b1);
        in_valid = 1'b0;
        step();

        // Backpressure: A, B, C back to back
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'hA;
        step();
        in_tag    = 32'hB;
        step();
        in_tag    = 32'hC;
        check("bp_in_ready_C", in_ready, 1'b0);
        check("bp_main_A", out_tag, 32'hA);
        step();
        out_ready = 1'b1;
        step();
        check("bp_second_B", out_tag, 32'hB);
        step();
        in_valid = 1'b0;
        check("bp_third_C", out_tag, 32'hC);
        step();
        check("bp_drained", out_valid, 1'b0);

        // Flush with both entries full and a new input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'h1;
        step();
        in_tag    = 32'h2;
        step();
        in_tag    = 32'hDEAD;
        flush     = 1'b1;
        step();
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset while FULL2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'h3;
        step();
        in_tag    = 32'h4;
        step();
        in_valid  = 1'b0;
        #2;
        reset_n   = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_addr", out_addr, '0);
        check("arst_tag", out_tag, '0);
        q.delete();
        #2;
        reset_n   = 1'b1;
        in_valid  = 1'b1;
        in_tag    = 32'h55;
        step();
        check("arst_first_valid", out_valid, 1'b1);
        check("arst_first_tag", out_tag, 32'h55);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            flush     = ($urandom % 20) == 0;
            out_ready = ($urandom % 10) < 6;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/agu_pipelined.md
Name: agu_pipelined

Overview:
- Parametrised, registered address-generation stage between operand fetch and memory access.
- Computes up to NCH memory-operand effective addresses per instruction, one per channel: source 1, source 2, destination, and so on.
- Each channel uses base + index*scale + disp, or a RIP-relative form.
- Adds a valid/ready handshake with a 2-entry skid buffer, a flush path, and a per-channel canonical-address fault check.

Parameters:
- AW, 64, address and operand width in bits.
- NCH, 3, number of address channels.
- VA_BITS, 48, implemented virtual-address bits for the canonical check; must satisfy VA_BITS <= AW.
- TAG_W, 32, width of the opaque sideband bundle (opcode, lengths, regs, etc.), passed through unmodified.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush (branch mispredict or writeback redirect).
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_rip  in  AW  RIP of the instruction.
- in_instr_len  in  8  instruction length in bytes.
- in_disp  in  AW  displacement, already sign-extended; shared by all channels.
- in_tag  in  TAG_W  sideband passthrough.
- in_mem_en  in  NCH  channel c is a memory operand.
- in_use_rip  in  NCH  channel c is RIP-relative.
- in_index_en  in  NCH  channel c uses an index register.
- in_base  in  NCH*AW  base register value per channel; channel c occupies slice c.
- in_index  in  NCH*AW  index register value per channel.
- in_scale  in  2*NCH  per-channel log2 scale: 0..3 means x1/x2/x4/x8.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_rip  out  AW  passthrough of in_rip.
- out_tag  out  TAG_W  passthrough of in_tag.
- out_addr_valid  out  NCH  copy of in_mem_en.
- out_addr  out  NCH*AW  effective address per channel.
- out_fault  out  NCH  non-canonical address per channel.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, in_ready=1.
  - out_addr, out_rip, out_tag, out_addr_valid and out_fault all 0.
  - Skid buffer empty, state EMPTY.
- Transfers:
  - Accept occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Per-channel arithmetic, computed combinationally on input and registered on accept; all sums modulo 2^AW, overflow silently wraps:
  - mem_en=0: addr=0, fault=0.
  - mem_en=1, use_rip=1: addr = in_rip + in_disp + zero-extended in_instr_len. Base, index and scale are ignored.
  - mem_en=1, use_rip=0: addr = base + (index_en ? index<<scale : 0) + in_disp.
  - fault=1 when mem_en=1 and addr bits [AW-1:VA_BITS-1] are not all equal. When VA_BITS==AW, fault is always 0.
- Latency: 1 cycle. A result accepted in cycle N is visible in cycle N+1 when the output register is free.
- State machine (main output register plus one skid register):
  - EMPTY: out_valid=0. Accept -> FULL1.
  - FULL1: out_valid=1.
    - Accept with no output transfer: new entry goes to skid -> FULL2.
    - Accept with output transfer: main register reloads -> FULL1.
    - Output transfer only -> EMPTY.
    - Neither: hold.
  - FULL2: out_valid=1, in_ready=0.
    - Output transfer: skid moves to main -> FULL1.
    - Otherwise hold.
- in_ready = (state != FULL2). It is registered-state-derived only, with no combinational path from out_ready.
- Output stability: while out_valid=1 and out_ready=0, every out_* signal holds stable.
- Flush:
  - Next state EMPTY; out_valid=0 from the following cycle.
  - Any accept in the flush cycle is discarded.
  - flush has priority over all simultaneous events.
- Reset asserted mid-operation clears both entries immediately; no partial result is ever emitted.
- Order: results leave in acceptance order; no reordering or duplication.
- Data registers need no reset beyond the values stated above; out_* must read 0 after reset.

Test Plan:
- RIP-relative: in_rip=0x400000, disp=0x10, len=7, ch0 mem_en=1 use_rip=1 -> next cycle out_addr[0]=0x400017, out_fault[0]=0, out_valid=1.
- SIB: ch1 base=0x1000, index=0x20, index_en=1, scale=3, disp=-8 (0xFFFF_FFFF_FFFF_FFF8) -> out_addr[1]=0x10F8. Channels with mem_en=0 give addr 0.
- Backpressure: out_ready=0, drive 3 back-to-back valid inputs A,B,C:
  - A is held in the main register and B is held in the skid.
  - in_ready=0 in the cycle C is presented.
  - Raising out_ready drains A, B, then C in order, with no loss or duplication.
- Wrap/fault: base=0xFFFF_FFFF_FFFF_FFF0, disp=0x20 -> addr=0x10, fault=0. base=0x0000_8000_0000_0000, disp=0 -> fault=1 with VA_BITS=48.
- Flush with both entries full and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the input offered in the flush cycle never appears.
- Async reset pulse while in FULL2 -> out_valid drops to 0 without waiting for a clock edge; after release, the first accepted input emerges one cycle later.
